// File: rtl/ahb_slave_sel.sv
// rtl/ahb_slave_sel.sv - AHB-Lite address decoder, data-phase select register and default ERROR slave
module ahb_slave_sel #(
  parameter int              NS       = 26,
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   BASE     = '0,
  parameter int              RGN_BITS = 12
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hready,
  output logic [NS-1:0] hsel,
  output logic          hsel_def,
  output logic [NS-1:0] sel_dp,
  output logic          sel_def_dp,
  output logic          def_hreadyout,
  output logic          def_hresp
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [AW-1:0] off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          def_req;
  logic          unused_htrans;

  logic [NS-1:0] sel_dp_d, sel_dp_q;
  logic          sel_def_dp_d, sel_def_dp_q;
  logic [1:0]    state_d, state_q;

  // Only the active/inactive distinction of htrans matters to the default slave
  assign unused_htrans = htrans[0];

  // Region decode; haddr below BASE is rejected explicitly so the subtraction cannot wrap into a slave
  always_comb begin
    off      = haddr - BASE;
    idx      = off >> RGN_BITS;
    in_range = (haddr >= BASE) && (idx < AW'(NS));
    hsel     = '0;
    for (int i = 0; i < NS; i++) begin
      if (in_range && (idx == AW'(i))) begin
        hsel[i] = 1'b1;
      end
    end
    hsel_def = ~|hsel;
  end

  // An active transfer to the default slave, accepted by the bus this cycle
  assign def_req = hready & hsel_def & htrans[1];

  // Data-phase select advances only when the address phase is accepted
  always_comb begin
    sel_dp_d     = sel_dp_q;
    sel_def_dp_d = sel_def_dp_q;
    if (hready) begin
      sel_dp_d     = hsel;
      sel_def_dp_d = hsel_def;
    end
  end

  // Default slave: two-cycle ERROR; ERR2 may chain straight into another ERR1
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = def_req ? ST_ERR1 : ST_IDLE;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = def_req ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset selects the default slave so hready is high and the bus cannot hang
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sel_dp_q     <= '0;
      sel_def_dp_q <= 1'b1;
      state_q      <= ST_IDLE;
    end else begin
      sel_dp_q     <= sel_dp_d;
      sel_def_dp_q <= sel_def_dp_d;
      state_q      <= state_d;
    end
  end

  assign sel_dp        = sel_dp_q;
  assign sel_def_dp    = sel_def_dp_q;
  assign def_hreadyout = (state_q != ST_ERR1);
  assign def_hresp     = (state_q != ST_IDLE);

endmodule
